// File: rtl/emb_lookup_pipe_if.sv
// Read port between emb_lookup_pipe and its external synchronous embedding RAM.
// master: the lookup engine issuing reads; slave: the RAM returning words.
interface emb_lookup_pipe_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_W     = 128
);
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_data;

  modport master (output ram_en, output ram_addr, input ram_data);
  modport slave  (input ram_en, input ram_addr, output ram_data);
endinterface

// File: rtl/emb_lookup_pipe.sv
// Embedding-table lookup: N latched indices -> N concatenated EMB_DIM vectors, one RAM word
// per cycle. Define EMB_PAD_ZERO_EN to add PAD_ID, whose characters read back as all-zero.
module emb_lookup_pipe #(
  parameter int unsigned N          = 8,
  parameter int unsigned CHAR_LEN   = 8,
  parameter int unsigned CHAR_NUM   = 200,
  parameter int unsigned EMB_DIM    = 24,
  parameter int unsigned DATA_N     = 8,
  parameter int unsigned N_LEN_W    = 16,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned ADDR_WIDTH = 10
`ifdef EMB_PAD_ZERO_EN
  ,
  parameter int unsigned PAD_ID     = 0
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic [N*CHAR_LEN-1:0]         d,
  output logic                          valid,
  output logic                          busy,
  output logic                          err,
  output logic [N*EMB_DIM*N_LEN_W-1:0]  q,
  emb_lookup_pipe_if.master             ram
);

  localparam int unsigned WORDS  = EMB_DIM / DATA_N;
  localparam int unsigned TOTAL  = N * WORDS;
  localparam int unsigned WORD_W = DATA_N * N_LEN_W;
  localparam int unsigned QW     = N * EMB_DIM * N_LEN_W;
  localparam int unsigned CW     = $clog2(N + 1);
  localparam int unsigned OW     = $clog2(WORDS + 1);
  localparam int unsigned WW     = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [N*CHAR_LEN-1:0]  idx_q, idx_d;
  logic [CW-1:0]          chr_q, chr_d;
  logic [OW-1:0]          off_q, off_d;
  logic                   en_q, en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   err_q, err_d;
  logic [QW-1:0]          q_q, q_d;
  logic [RAM_LAT-1:0]     pipe_vld_q;
  logic [RAM_LAT-1:0]     pipe_pad_q;
  logic [WW-1:0]          pipe_w_q [RAM_LAT];

  logic                   issue, flush;
  logic [CW-1:0]          iss_chr;
  logic [OW-1:0]          iss_off;
  logic [CHAR_LEN-1:0]    iss_idx, iss_row;
  logic                   iss_oob, iss_pad;
  logic [WW-1:0]          iss_w;

  // Select the word to issue this cycle; word 0 is issued straight from d on the start edge.
  always_comb begin
    issue   = 1'b0;
    iss_chr = chr_q;
    iss_off = off_q;
    iss_idx = '0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          issue   = 1'b1;
          iss_chr = '0;
          iss_off = '0;
          iss_idx = d[CHAR_LEN-1:0];
        end
      end
      StFetch: begin
        if (run && (chr_q < CW'(N))) begin
          issue   = 1'b1;
          iss_idx = idx_q[chr_q*CHAR_LEN +: CHAR_LEN];
        end
      end
      default: ;
    endcase
  end

  assign iss_oob = (32'(iss_idx) >= CHAR_NUM);
  assign iss_row = iss_oob ? '0 : iss_idx;
  assign iss_w   = WW'(iss_chr) * WW'(WORDS) + WW'(iss_off);
`ifdef EMB_PAD_ZERO_EN
  assign iss_pad = (32'(iss_idx) == PAD_ID);
`else
  assign iss_pad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chr_d   = chr_q;
    off_d   = off_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    err_d   = err_q;
    q_d     = q_q;
    flush   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          idx_d   = d;
          state_d = StFetch;
        end
      end
      StFetch, StDrain: begin
        if (!run) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else begin
          if (state_q == StFetch && chr_q >= CW'(N)) state_d = StDrain;
          if (pipe_vld_q[RAM_LAT-1]) begin
            q_d[pipe_w_q[RAM_LAT-1]*WORD_W +: WORD_W] =
                pipe_pad_q[RAM_LAT-1] ? '0 : ram.ram_data;
            if (pipe_w_q[RAM_LAT-1] == WW'(TOTAL - 1)) state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!run) begin
          state_d = StIdle;
          q_d     = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      en_d   = 1'b1;
      addr_d = ADDR_WIDTH'(iss_row) * ADDR_WIDTH'(WORDS) + ADDR_WIDTH'(iss_off);
      err_d  = err_q | iss_oob;
      if (iss_off == OW'(WORDS - 1)) begin
        chr_d = iss_chr + CW'(1);
        off_d = '0;
      end else begin
        chr_d = iss_chr;
        off_d = iss_off + OW'(1);
      end
    end

    // Abort discards everything in flight; the address register keeps its last value.
    if (flush) begin
      q_d   = '0;
      err_d = 1'b0;
      en_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      chr_q      <= '0;
      off_q      <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      q_q        <= '0;
      pipe_vld_q <= '0;
      pipe_pad_q <= '0;
      for (int i = 0; i < RAM_LAT; i++) pipe_w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chr_q   <= chr_d;
      off_q   <= off_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      q_q     <= q_d;
      if (flush) begin
        pipe_vld_q <= '0;
      end else begin
        pipe_vld_q[0] <= issue;
        pipe_pad_q[0] <= iss_pad;
        pipe_w_q[0]   <= iss_w;
        for (int i = 1; i < RAM_LAT; i++) begin
          pipe_vld_q[i] <= pipe_vld_q[i-1];
          pipe_pad_q[i] <= pipe_pad_q[i-1];
          pipe_w_q[i]   <= pipe_w_q[i-1];
        end
      end
    end
  end

  assign valid        = (state_q == StDone);
  assign busy         = (state_q == StFetch) || (state_q == StDrain);
  assign err          = err_q;
  assign q            = q_q;
  assign ram.ram_en   = en_q;
  assign ram.ram_addr = addr_q;

endmodule

// File: doc/emb_lookup_pipe.md
Name: emb_lookup_pipe

Overview:
Parametrised embedding-table lookup for the training forward path. It maps N character indices to N concatenated EMB_DIM-wide vectors by reading an external synchronous embedding RAM one DATA_N-element word per cycle. Compared with the existing embedding forward block, it adds configurable RAM read latency, input latching at start, a RAM enable, a busy flag and out-of-range index detection. It sits between the character-index source and the first dense layer.

Parameters:
N, 8, number of characters per sample
CHAR_LEN, 8, bits per character index
CHAR_NUM, 200, number of table rows; valid indices are 0..CHAR_NUM-1
EMB_DIM, 24, elements per embedding vector; must be divisible by DATA_N
DATA_N, 8, elements per RAM word
N_LEN_W, 16, bits per element
RAM_LAT, 1, RAM read latency in cycles, range 1..4
ADDR_WIDTH, 10, RAM address width; must satisfy 2^ADDR_WIDTH >= CHAR_NUM*EMB_DIM/DATA_N

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  level request; hold high until consumed
d  in  N*CHAR_LEN  indices; char i is d[i*CHAR_LEN +: CHAR_LEN]
valid  out  1  q complete and stable
busy  out  1  lookup in progress
err  out  1  at least one index was >= CHAR_NUM in the current lookup
q  out  N*EMB_DIM*N_LEN_W  result; word w (0..N*WORDS-1) at q[w*DATA_N*N_LEN_W +: DATA_N*N_LEN_W]
ram_en  out  1  RAM read enable
ram_addr  out  ADDR_WIDTH  RAM word address
ram_data  in  DATA_N*N_LEN_W  RAM read data, RAM_LAT cycles after the address/enable edge

Behaviour:
- WORDS = EMB_DIM/DATA_N; TOTAL = N*WORDS. Word w belongs to char c = w/WORDS, offset o = w%WORDS. Address = WORDS*d[c] + o.
- Reset (rst_n low at a clock edge): state IDLE; valid=0, busy=0, err=0, ram_en=0, ram_addr=0, all q words 0, internal counters and the capture pipeline cleared. Reset overrides all other inputs.
- FSM states:
  - IDLE: on an edge with run=1, latch d into an internal register, issue word 0 (ram_en=1, ram_addr for w=0), set busy=1 and go to FETCH. d is not sampled again until the next start.
  - FETCH: issue words 1..TOTAL-1 on consecutive edges, one per cycle. ram_en goes low on the edge after the last issue, then go to DRAIN.
  - DRAIN: wait for the outstanding captures to complete.
  - DONE: valid=1, busy=0; q and err are held.
- Capture: a RAM_LAT-deep valid/index shift pipeline tracks issued reads. Word w is captured into q word w at the edge RAM_LAT cycles after its issue edge.
- Timing: if run is sampled at edge E0, captures occur at edges E0+RAM_LAT .. E0+TOTAL-1+RAM_LAT. At that last edge the FSM enters DONE, so valid rises TOTAL+RAM_LAT-1 edges after E0. Example: TOTAL=24, RAM_LAT=1 gives valid high after edge E0+24.
- DONE with run=1: hold all outputs.
- DONE with run=0: on the next edge clear q, valid and err and go to IDLE. A new lookup can start on the following edge.
- Abort: run=0 in any FETCH or DRAIN cycle goes to IDLE on that edge. q, err, the pipeline and ram_en are cleared and no capture happens afterwards. Late RAM data is ignored.
- Out-of-range index: if a latched index is >= CHAR_NUM, its words use row 0 addresses and err is set at that character's first issue edge. err is sticky until the return to IDLE.
- ram_addr holds its last value while ram_en=0.
- q never shows partial results while valid=1.

Optional Feature:
EMB_PAD_ZERO_EN: adds parameter PAD_ID (default 0).
- Defined: characters whose latched index equals PAD_ID still issue reads, so timing is unchanged. Their q words are captured as all-zero regardless of ram_data.
- Undefined: PAD_ID does not exist and all characters take ram_data.

Test Plan:
- Basic lookup, RAM_LAT=1, RAM word content = address: d = {0,1,...,7}, run held -> valid rises 24 edges after start; q word w = 3*c+o; err=0; ram_en high exactly 24 cycles.
- RAM_LAT=3, same stimulus -> valid rises 26 edges after start; q identical to the RAM_LAT=1 result.
- Change d to all 5 two cycles after start -> q still reflects the original d (input latched at start).
- d[3]=250 with CHAR_NUM=200 -> err=1 from the char-3 issue onward; char 3 words = row-0 data; err clears after run drops.
- Drop run at edge 10 of FETCH -> busy=0, ram_en=0, q all zero next cycle. Restart with run=1 -> full correct result, no stale captures.
- With EMB_PAD_ZERO_EN, PAD_ID=0, d={0,4,0,...} -> chars 0 and 2 zero in q, char 1 = rows 12..14 data; latency unchanged.
